// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/write-back stage: loads, stores, register write-back, jump redirect, halt
//
// Optional feature: define MEM_TIMEOUT_EN to abandon a memory access that is
// not acknowledged within TIMEOUT_CYCLES MEM_WAIT cycles (mem_err_o pulses).
// Without it, MEM_WAIT waits indefinitely and mem_err_o is tied 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i/ready_o   instruction handshake from execute; ready_o = (state == IDLE)
//   flags_i           ALU flags (BLANK/WRITE/READ/JUMP/STOP)
//   result_i          write-back data, store data or jump target/offset
//   addr_i            memory address
//   dest_i            destination register index
//   store_i           with WRITE flags, selects a memory store instead of a register write
//   jmp_rel_i, pc_i   relative jump select and the instruction's PC
//   mem_*             data-memory req/ack interface
//   wb_*              register-file write-back (wb_en_o is a 1-cycle strobe)
//   jmp_en_o/addr_o   fetch redirect (jmp_en_o is a 1-cycle strobe)
//   halt_o            sticky halt, cleared only by reset
//   mem_err_o         memory timeout pulse

module mem_wb_stage #(
    parameter int D_BITS         = 32,
    parameter int A_BITS         = 10,
    parameter int FLAGS_NR       = 3,
    parameter int REG_BITS       = 3,
    parameter int OFF_BITS       = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [FLAGS_NR-1:0] flags_i,
    input  logic [D_BITS-1:0]   result_i,
    input  logic [A_BITS-1:0]   addr_i,
    input  logic [REG_BITS-1:0] dest_i,
    input  logic                store_i,
    input  logic                jmp_rel_i,
    input  logic [A_BITS-1:0]   pc_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [A_BITS-1:0]   mem_addr_o,
    output logic [D_BITS-1:0]   mem_wdata_o,
    input  logic [D_BITS-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic                wb_en_o,
    output logic [REG_BITS-1:0] wb_dest_o,
    output logic [D_BITS-1:0]   wb_data_o,
    output logic                jmp_en_o,
    output logic [A_BITS-1:0]   jmp_addr_o,
    output logic                halt_o,
    output logic                mem_err_o
);

    // ALU flag encodings shared with the execute stage
    localparam logic [FLAGS_NR-1:0] F_BLANK = FLAGS_NR'(0);
    localparam logic [FLAGS_NR-1:0] F_WRITE = FLAGS_NR'(1);
    localparam logic [FLAGS_NR-1:0] F_READ  = FLAGS_NR'(2);
    localparam logic [FLAGS_NR-1:0] F_JUMP  = FLAGS_NR'(3);
    localparam logic [FLAGS_NR-1:0] F_STOP  = FLAGS_NR'(4);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALTED   = 2'd2;

    logic [1:0]          state;
    logic [REG_BITS-1:0] rd_dest;    // load destination held across MEM_WAIT
    logic [A_BITS-1:0]   rel_target;

    assign ready_o = (state == IDLE);

    // Relative jumps: sign-extend the offset field and wrap modulo 2^A_BITS
    assign rel_target = pc_i + {{(A_BITS-OFF_BITS){result_i[OFF_BITS-1]}},
                                result_i[OFF_BITS-1:0]};

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
    logic [CNT_BITS-1:0] tmo_cnt;
    logic                mem_err_q;
    assign mem_err_o = mem_err_q;
`else
    assign mem_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_dest     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            wb_en_o     <= 1'b0;
            wb_dest_o   <= '0;
            wb_data_o   <= '0;
            jmp_en_o    <= 1'b0;
            jmp_addr_o  <= '0;
            halt_o      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt     <= '0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            // strobes default low so they only ever last one cycle
            wb_en_o  <= 1'b0;
            jmp_en_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        case (flags_i)
                            F_WRITE: begin
                                if (store_i) begin
                                    mem_req_o   <= 1'b1;
                                    mem_we_o    <= 1'b1;
                                    mem_addr_o  <= addr_i;
                                    mem_wdata_o <= result_i;
                                    state       <= MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
                                    tmo_cnt     <= '0;
`endif
                                end else begin
                                    wb_en_o   <= 1'b1;
                                    wb_dest_o <= dest_i;
                                    wb_data_o <= result_i;
                                end
                            end
                            F_READ: begin
                                mem_req_o  <= 1'b1;
                                mem_we_o   <= 1'b0;
                                mem_addr_o <= addr_i;
                                rd_dest    <= dest_i;
                                state      <= MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
                                tmo_cnt    <= '0;
`endif
                            end
                            F_JUMP: begin
                                jmp_en_o   <= 1'b1;
                                jmp_addr_o <= jmp_rel_i ? rel_target : result_i[A_BITS-1:0];
                            end
                            F_STOP: begin
                                halt_o <= 1'b1;
                                state  <= HALTED;
                            end
                            default: ;  // BLANK and undefined encodings do nothing
                        endcase
                    end
                end

                MEM_WAIT: begin
                    // an ack on the limit cycle takes priority over the timeout
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= IDLE;
                        if (!mem_we_o) begin
                            wb_en_o   <= 1'b1;
                            wb_dest_o <= rd_dest;
                            wb_data_o <= mem_rdata_i;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mem_err_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                HALTED: ;  // only reset leaves this state

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    localparam logic [2:0] F_BLANK = 3'd0;
    localparam logic [2:0] F_WRITE = 3'd1;
    localparam logic [2:0] F_READ  = 3'd2;
    localparam logic [2:0] F_JUMP  = 3'd3;
    localparam logic [2:0] F_STOP  = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  flags_i = '0;
    logic [31:0] result_i = '0;
    logic [9:0]  addr_i = '0;
    logic [2:0]  dest_i = '0;
    logic        store_i = 1'b0;
    logic        jmp_rel_i = 1'b0;
    logic [9:0]  pc_i = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        wb_en_o;
    logic [2:0]  wb_dest_o;
    logic [31:0] wb_data_o;
    logic        jmp_en_o;
    logic [9:0]  jmp_addr_o;
    logic        halt_o;
    logic        mem_err_o;

    int checks = 0;
    int errors = 0;

    // reference state: memory contents and last write-back values
    logic [31:0] mem_model [int];
    logic [31:0] exp_wb_data = '0;
    logic [2:0]  exp_wb_dest = '0;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .flags_i(flags_i), .result_i(result_i), .addr_i(addr_i), .dest_i(dest_i),
        .store_i(store_i), .jmp_rel_i(jmp_rel_i), .pc_i(pc_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .wb_en_o(wb_en_o), .wb_dest_o(wb_dest_o), .wb_data_o(wb_data_o),
        .jmp_en_o(jmp_en_o), .jmp_addr_o(jmp_addr_o), .halt_o(halt_o),
        .mem_err_o(mem_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic st, input logic [31:0] res,
                         input logic [9:0] a, input logic [2:0] d, input logic rel,
                         input logic [9:0] pc);
        valid_i = 1'b1; flags_i = f; store_i = st; result_i = res;
        addr_i = a; dest_i = d; jmp_rel_i = rel; pc_i = pc;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic reg_write(input logic [31:0] d, input logic [2:0] r);
        issue(F_WRITE, 1'b0, d, 10'($urandom), r, 1'b0, 10'd0);
        exp_wb_data = d; exp_wb_dest = r;
        check("wr_en", 32'(wb_en_o), 32'd1);
        check("wr_dest", 32'(wb_dest_o), 32'(r));
        check("wr_data", wb_data_o, d);
        check("wr_ready", 32'(ready_o), 32'd1);
        tick();
        check("wr_pulse", 32'(wb_en_o), 32'd0);
        check("wr_hold", wb_data_o, d);
    endtask

    // load or store with the ack on the lat-th MEM_WAIT cycle
    task automatic mem_op(input logic is_store, input logic [9:0] a, input logic [31:0] d,
                          input logic [2:0] r, input int lat);
        logic [31:0] rd;
        rd = mem_model.exists(int'(a)) ? mem_model[int'(a)] : $urandom;
        issue(is_store ? F_WRITE : F_READ, is_store, d, a, r, 1'b0, 10'd0);
        for (int i = 0; i < lat; i++) begin
            check("mem_req", 32'(mem_req_o), 32'd1);
            check("mem_addr", 32'(mem_addr_o), 32'(a));
            check("mem_we", 32'(mem_we_o), 32'(is_store));
            if (is_store) check("mem_wdata", mem_wdata_o, d);
            check("mem_ready", 32'(ready_o), 32'd0);
            check("mem_no_wb", 32'(wb_en_o), 32'd0);
            if (i == lat - 1) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = is_store ? 32'($urandom) : rd;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        check("mem_done_req", 32'(mem_req_o), 32'd0);
        check("mem_done_ready", 32'(ready_o), 32'd1);
        if (is_store) begin
            mem_model[int'(a)] = d;
            check("st_no_wb", 32'(wb_en_o), 32'd0);
            check("st_wb_hold", wb_data_o, exp_wb_data);
        end else begin
            exp_wb_data = rd; exp_wb_dest = r;
            check("ld_wb_en", 32'(wb_en_o), 32'd1);
            check("ld_wb_data", wb_data_o, rd);
            check("ld_wb_dest", 32'(wb_dest_o), 32'(r));
        end
        tick();
        check("mem_wb_pulse", 32'(wb_en_o), 32'd0);
    endtask

    function automatic logic [9:0] jump_model(input logic rel, input logic [9:0] pc,
                                              input logic [31:0] res);
        int off;
        if (!rel) return res[9:0];
        off = int'(res & 32'h3F);
        if (off >= 32) off -= 64;
        return 10'((int'(pc) + off + 1024) % 1024);
    endfunction

    task automatic jump(input logic rel, input logic [9:0] pc, input logic [31:0] res);
        logic [9:0] exp;
        exp = jump_model(rel, pc, res);
        issue(F_JUMP, 1'b0, res, 10'd0, 3'd0, rel, pc);
        check("jmp_en", 32'(jmp_en_o), 32'd1);
        check("jmp_addr", 32'(jmp_addr_o), 32'(exp));
        check("jmp_no_wb", 32'(wb_en_o), 32'd0);
        tick();
        check("jmp_pulse", 32'(jmp_en_o), 32'd0);
        check("jmp_hold", 32'(jmp_addr_o), 32'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_we"}, 32'(mem_we_o), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        check({tag, "_wdata"}, mem_wdata_o, 32'd0);
        check({tag, "_wb_en"}, 32'(wb_en_o), 32'd0);
        check({tag, "_wb_dest"}, 32'(wb_dest_o), 32'd0);
        check({tag, "_wb_data"}, wb_data_o, 32'd0);
        check({tag, "_jmp_en"}, 32'(jmp_en_o), 32'd0);
        check({tag, "_jmp_addr"}, 32'(jmp_addr_o), 32'd0);
        check({tag, "_halt"}, 32'(halt_o), 32'd0);
        check({tag, "_err"}, 32'(mem_err_o), 32'd0);
        check({tag, "_ready"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int op;
        // reset state
        tick(); tick();
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // ack outside MEM_WAIT is ignored
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        mem_ack_i = 1'b0;
        check("stray_ack_wb", 32'(wb_en_o), 32'd0);
        check("stray_ack_ready", 32'(ready_o), 32'd1);

        // directed cases
        reg_write(32'h0000_00A5, 3'd3);
        issue(F_BLANK, 1'b0, 32'h55, 10'd1, 3'd1, 1'b0, 10'd0);
        check("blank_wb", 32'(wb_en_o), 32'd0);
        check("blank_jmp", 32'(jmp_en_o), 32'd0);
        check("blank_req", 32'(mem_req_o), 32'd0);
        issue(3'd7, 1'b1, 32'h66, 10'd2, 3'd2, 1'b1, 10'd3);
        check("undef_wb", 32'(wb_en_o), 32'd0);
        check("undef_req", 32'(mem_req_o), 32'd0);
        check("undef_ready", 32'(ready_o), 32'd1);

        mem_model[32'h12] = 32'hDEAD_BEEF;
        mem_op(1'b0, 10'h012, 32'h0, 3'd5, 3);
        mem_op(1'b1, 10'h3FF, 32'h0000_1234, 3'd0, 2);
        mem_op(1'b0, 10'h3FF, 32'h0, 3'd6, 1);
        jump(1'b1, 10'h005, 32'h0000_003E);
        jump(1'b1, 10'h001, 32'h0000_003E);
        jump(1'b0, 10'h100, 32'hABCD_E2F7);

        // randomized operations checked against the reference model
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: reg_write($urandom, 3'($urandom));
                1: mem_op(1'b0, 10'($urandom_range(0, 15)), 32'h0, 3'($urandom),
                          int'($urandom_range(1, 5)));
                2: mem_op(1'b1, 10'($urandom_range(0, 15)), $urandom, 3'd0,
                          int'($urandom_range(1, 5)));
                default: jump(1'($urandom), 10'($urandom), $urandom);
            endcase
        end

`ifdef MEM_TIMEOUT_EN
        issue(F_READ, 1'b0, 32'h0, 10'h0AA, 3'd4, 1'b0, 10'd0);
        for (int i = 0; i < 16; i++) begin
            check("tmo_req", 32'(mem_req_o), 32'd1);
            check("tmo_err_early", 32'(mem_err_o), 32'd0);
            tick();
        end
        check("tmo_err", 32'(mem_err_o), 32'd1);
        check("tmo_req_drop", 32'(mem_req_o), 32'd0);
        check("tmo_no_wb", 32'(wb_en_o), 32'd0);
        check("tmo_ready", 32'(ready_o), 32'd1);
        tick();
        check("tmo_err_pulse", 32'(mem_err_o), 32'd0);
`endif

        // halt: later instructions are ignored
        issue(F_STOP, 1'b0, 32'h0, 10'd0, 3'd0, 1'b0, 10'd0);
        check("halt", 32'(halt_o), 32'd1);
        check("halt_ready", 32'(ready_o), 32'd0);
        issue(F_WRITE, 1'b0, 32'h77, 10'd0, 3'd1, 1'b0, 10'd0);
        issue(F_READ, 1'b0, 32'h0, 10'd9, 3'd1, 1'b0, 10'd0);
        check("halt_no_wb", 32'(wb_en_o), 32'd0);
        check("halt_no_req", 32'(mem_req_o), 32'd0);
        check("halt_sticky", 32'(halt_o), 32'd1);
        check("halt_wb_hold", wb_data_o, exp_wb_data);

        // reset clears halt
        rst_n = 1'b0;
        tick();
        check_all_zero("halt_rst");
        rst_n = 1'b1;
        tick();

        // reset in the middle of a load
        issue(F_READ, 1'b0, 32'h0, 10'h012, 3'd5, 1'b0, 10'd0);
        check("mid_req", 32'(mem_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("mid_no_wb", 32'(wb_en_o), 32'd0);
        exp_wb_data = '0;
        reg_write(32'hCAFE_0001, 3'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
